// File: rtl/fp_alu_pkg.sv
// Shared constants for the pipelined floating-point add/multiply unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_alu_pkg;

    // Operation select encoding on in_op
    localparam int OP_ADD = 1;
    localparam int OP_MUL = 0;

    // Default field widths of the unified internal format
    localparam int DEF_EXP_W = 6;
    localparam int DEF_MAN_W = 22;
    localparam int DEF_MUL_W = 11;

    // Exponent bias for a given exponent width
    function automatic int bias_of(input int exp_w);
        return (2 ** (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter over a W-bit vector; an all-zero input returns W.
// Latency: combinational.
// Backpressure: n/a.
module fp_lzc #(
    parameter int W  = 22,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt
);

    // Scan upward so the highest set bit writes the count last
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) begin
                cnt = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_alu_pipe.sv
// Four-stage pipelined floating-point add/multiply with normalisation and ovf/unf flags.
// Latency: 4 cycles from accepted beat to out_valid when not stalled.
// Backpressure: in_ready = ~out_valid | out_ready; when low every stage holds (global stall).
module fp_alu_pipe
    import fp_alu_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    parameter int MUL_W = DEF_MUL_W,
    parameter int BIAS  = bias_of(EXP_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic             a_sgn,
    input  logic             b_sgn,
    input  logic [EXP_W-1:0] a_exp,
    input  logic [EXP_W-1:0] b_exp,
    input  logic [MAN_W-1:0] a_man,
    input  logic [MAN_W-1:0] b_man,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             y_sgn,
    output logic [EXP_W-1:0] y_exp,
    output logic [MAN_W-1:0] y_man,
    output logic             y_ovf,
    output logic             y_unf
);

    // Exponents travel as EXP_W+2-bit two's complement so multiply underflow stays visible
    localparam int EW2 = EXP_W + 2;
    localparam int CW  = $clog2(MAN_W + 1);

    // Single shared advance enable for the whole pipe
    logic en;
    assign in_ready = ~out_valid | out_ready;
    assign en       = in_ready;

    // ---------------- S1: operand compare / multiply ----------------
    logic             a_zero, b_zero, a_big;
    logic [MUL_W-1:0] a_hi, b_hi;
    logic [MAN_W-1:0] prod;
    logic             d1_sgn, d1_sub;
    logic [EW2-1:0]   d1_exp;
    logic [MAN_W-1:0] d1_man_l, d1_man_s;
    logic [EXP_W-1:0] d1_sh;

    assign a_zero = (a_man == '0);
    assign b_zero = (b_man == '0);
    // A zero operand is always the smaller one so its exponent never wins
    assign a_big  = b_zero | (~a_zero & ((a_exp > b_exp) | ((a_exp == b_exp) & (a_man >= b_man))));
    assign a_hi   = a_man[MAN_W-1 -: MUL_W];
    assign b_hi   = b_man[MAN_W-1 -: MUL_W];
    assign prod   = MAN_W'(a_hi) * MAN_W'(b_hi);

    // Order add operands by magnitude, or form the product; multiply reuses the add datapath with a zero addend
    always_comb begin
        d1_sgn   = a_sgn ^ b_sgn;
        d1_sub   = 1'b0;
        d1_exp   = EW2'(a_exp) + EW2'(b_exp) - EW2'(BIAS);
        d1_man_l = prod;
        d1_man_s = '0;
        d1_sh    = '0;
        if (in_op == 1'(OP_ADD)) begin
            d1_sub = a_sgn ^ b_sgn;
            if (a_big) begin
                d1_sgn   = a_sgn;
                d1_exp   = EW2'(a_exp);
                d1_man_l = a_man;
                d1_man_s = b_man;
                d1_sh    = a_exp - b_exp;
            end else begin
                d1_sgn   = b_sgn;
                d1_exp   = EW2'(b_exp);
                d1_man_l = b_man;
                d1_man_s = a_man;
                d1_sh    = b_exp - a_exp;
            end
        end
    end

    logic             s1_vld, s1_sgn, s1_sub;
    logic [EW2-1:0]   s1_exp;
    logic [MAN_W-1:0] s1_man_l, s1_man_s;
    logic [EXP_W-1:0] s1_sh;

    // S1 register: capture accepted beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_sgn   <= 1'b0;
            s1_sub   <= 1'b0;
            s1_exp   <= '0;
            s1_man_l <= '0;
            s1_man_s <= '0;
            s1_sh    <= '0;
        end else if (en) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_sgn   <= d1_sgn;
                s1_sub   <= d1_sub;
                s1_exp   <= d1_exp;
                s1_man_l <= d1_man_l;
                s1_man_s <= d1_man_s;
                s1_sh    <= d1_sh;
            end
        end
    end

    // ---------------- S2: align shift ----------------
    logic [MAN_W-1:0] d2_man_s;
    assign d2_man_s = (int'(s1_sh) >= MAN_W) ? '0 : (s1_man_s >> s1_sh);

    logic             s2_vld, s2_sgn, s2_sub;
    logic [EW2-1:0]   s2_exp;
    logic [MAN_W-1:0] s2_man_l, s2_man_s;

    // S2 register: aligned smaller mantissa, truncated bits dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld   <= 1'b0;
            s2_sgn   <= 1'b0;
            s2_sub   <= 1'b0;
            s2_exp   <= '0;
            s2_man_l <= '0;
            s2_man_s <= '0;
        end else if (en) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_sgn   <= s1_sgn;
                s2_sub   <= s1_sub;
                s2_exp   <= s1_exp;
                s2_man_l <= s1_man_l;
                s2_man_s <= d2_man_s;
            end
        end
    end

    // ---------------- S3: add / subtract and carry fix ----------------
    logic [MAN_W:0]   sum_add, sum_dif;
    logic             d3_sgn;
    logic [EW2-1:0]   d3_exp;
    logic [MAN_W-1:0] d3_man;

    assign sum_add = {1'b0, s2_man_l} + {1'b0, s2_man_s};
    assign sum_dif = {1'b0, s2_man_l} - {1'b0, s2_man_s};

    // Carry shifts right and bumps the exponent; a borrow (possible only with an
    // unnormalised larger-exponent operand) is folded back to a magnitude with the sign flipped
    always_comb begin
        d3_sgn = s2_sgn;
        d3_exp = s2_exp;
        d3_man = sum_add[MAN_W-1:0];
        if (s2_sub) begin
            if (sum_dif[MAN_W]) begin
                d3_sgn = ~s2_sgn;
                d3_man = s2_man_s - s2_man_l;
            end else begin
                d3_man = sum_dif[MAN_W-1:0];
            end
        end else if (sum_add[MAN_W]) begin
            d3_man = sum_add[MAN_W:1];
            d3_exp = s2_exp + EW2'(1);
        end
    end

    logic             s3_vld, s3_sgn;
    logic [EW2-1:0]   s3_exp;
    logic [MAN_W-1:0] s3_man;

    // S3 register: raw sum with exponent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_vld <= 1'b0;
            s3_sgn <= 1'b0;
            s3_exp <= '0;
            s3_man <= '0;
        end else if (en) begin
            s3_vld <= s2_vld;
            if (s2_vld) begin
                s3_sgn <= d3_sgn;
                s3_exp <= d3_exp;
                s3_man <= d3_man;
            end
        end
    end

    // ---------------- S4: LZC, normalise, flags ----------------
    logic [CW-1:0]    lz;
    logic [MAN_W-1:0] man_n;
    logic             d4_sgn, d4_ovf, d4_unf;
    logic [EXP_W-1:0] d4_exp;
    logic [MAN_W-1:0] d4_man;
    int               lz_i, e_i, sh_i, en_i;

    fp_lzc #(.W(MAN_W), .CW(CW)) u_lzc (
        .din (s3_man),
        .cnt (lz)
    );

    // Normalise no further than exponent 0 (gradual underflow), then classify zero / overflow / underflow
    always_comb begin
        lz_i   = int'(lz);
        e_i    = int'($signed(s3_exp));
        sh_i   = 0;
        if (e_i >= 0) begin
            sh_i = (lz_i < e_i) ? lz_i : e_i;
        end
        man_n  = s3_man << sh_i;
        en_i   = e_i - sh_i;
        d4_sgn = s3_sgn;
        d4_exp = EXP_W'(en_i);
        d4_man = man_n;
        d4_ovf = 1'b0;
        d4_unf = 1'b0;
        if (man_n == '0) begin
            d4_sgn = 1'b0;
            d4_exp = '0;
            d4_man = '0;
        end else if (en_i > (2 ** EXP_W) - 1) begin
            d4_exp = '1;
            d4_man = '1;
            d4_ovf = 1'b1;
        end else if (en_i < 0) begin
            d4_sgn = 1'b0;
            d4_exp = '0;
            d4_man = '0;
            d4_unf = 1'b1;
        end
    end

    // Output register: held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y_sgn     <= 1'b0;
            y_exp     <= '0;
            y_man     <= '0;
            y_ovf     <= 1'b0;
            y_unf     <= 1'b0;
        end else if (en) begin
            out_valid <= s3_vld;
            if (s3_vld) begin
                y_sgn <= d4_sgn;
                y_exp <= d4_exp;
                y_man <= d4_man;
                y_ovf <= d4_ovf;
                y_unf <= d4_unf;
            end
        end
    end

endmodule

// File: tb/tb_fp_alu_pipe.sv
// Directed bench for fp_alu_pipe with hand-computed results at default widths.
// Latency: checks 4-cycle issue-to-result.
// Backpressure: exercises a 3-cycle consumer stall and a mid-stream reset.
module tb_fp_alu_pipe;
    import fp_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_op;
    logic        a_sgn, b_sgn;
    logic [5:0]  a_exp, b_exp;
    logic [21:0] a_man, b_man;
    logic        out_valid, out_ready;
    logic        y_sgn;
    logic [5:0]  y_exp;
    logic [21:0] y_man;
    logic        y_ovf, y_unf;

    int checks = 0;
    int passes = 0;

    fp_alu_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .a_sgn     (a_sgn),
        .b_sgn     (b_sgn),
        .a_exp     (a_exp),
        .b_exp     (b_exp),
        .a_man     (a_man),
        .b_man     (b_man),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_sgn     (y_sgn),
        .y_exp     (y_exp),
        .y_man     (y_man),
        .y_ovf     (y_ovf),
        .y_unf     (y_unf)
    );

    always #5 clk = ~clk;

    localparam int NV = 15;
    string       tag_t [NV];
    logic        op_t  [NV];
    logic [28:0] a_t   [NV];
    logic [28:0] b_t   [NV];
    logic [30:0] y_t   [NV];

    function automatic logic [28:0] opnd(input logic s, input logic [5:0] e, input logic [21:0] m);
        return {s, e, m};
    endfunction

    function automatic logic [30:0] res(input logic s, input logic [5:0] e, input logic [21:0] m,
                                        input logic o, input logic u);
        return {s, e, m, o, u};
    endfunction

    function automatic logic [30:0] ypk();
        return {y_sgn, y_exp, y_man, y_ovf, y_unf};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    task automatic drive(input int k);
        in_op = op_t[k];
        {a_sgn, a_exp, a_man} = a_t[k];
        {b_sgn, b_exp, b_man} = b_t[k];
    endtask

    // Issue one beat with an idle consumer path and wait (bounded) for its result
    task automatic run_one(input int k);
        int n;
        n = 0;
        drive(k);
        in_valid = 1'b1;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (out_valid) n = i;
        end
        chk({tag_t[k], "_lat"}, 32'(n), 32'd4);
        chk(tag_t[k], 32'(ypk()), 32'(y_t[k]));
    endtask

    initial begin
        int idx, got, stall_cyc, stall_bad, extra, stale;
        logic acc;
        logic [30:0] held;

        // Vector table: tag, op, a, b, expected y
        tag_t[0]  = "add05";     op_t[0]  = 1'b1; a_t[0]  = opnd(0,31,22'h200000); b_t[0]  = opnd(0,31,22'h200000); y_t[0]  = res(0,32,22'h200000,0,0);
        tag_t[1]  = "mul05";     op_t[1]  = 1'b0; a_t[1]  = opnd(0,31,22'h200000); b_t[1]  = opnd(0,31,22'h200000); y_t[1]  = res(0,30,22'h200000,0,0);
        tag_t[2]  = "shift25";   op_t[2]  = 1'b1; a_t[2]  = opnd(0,40,22'h300000); b_t[2]  = opnd(0,15,22'h200000); y_t[2]  = res(0,40,22'h300000,0,0);
        tag_t[3]  = "cancel";    op_t[3]  = 1'b1; a_t[3]  = opnd(0,31,22'h200000); b_t[3]  = opnd(1,31,22'h200000); y_t[3]  = res(0,0,22'h0,0,0);
        tag_t[4]  = "zero_op";   op_t[4]  = 1'b1; a_t[4]  = opnd(0,40,22'h0);      b_t[4]  = opnd(1,20,22'h300000); y_t[4]  = res(1,20,22'h300000,0,0);
        tag_t[5]  = "ovf_mul";   op_t[5]  = 1'b0; a_t[5]  = opnd(0,63,22'h3FFFFF); b_t[5]  = opnd(0,63,22'h3FFFFF); y_t[5]  = res(0,63,22'h3FFFFF,1,0);
        tag_t[6]  = "unf_mul";   op_t[6]  = 1'b0; a_t[6]  = opnd(0,0,22'h200000);  b_t[6]  = opnd(0,0,22'h200000);  y_t[6]  = res(0,0,22'h0,0,1);
        tag_t[7]  = "add_align"; op_t[7]  = 1'b1; a_t[7]  = opnd(0,32,22'h200000); b_t[7]  = opnd(0,31,22'h200000); y_t[7]  = res(0,32,22'h300000,0,0);
        tag_t[8]  = "sub_norm";  op_t[8]  = 1'b1; a_t[8]  = opnd(0,32,22'h200000); b_t[8]  = opnd(1,31,22'h300000); y_t[8]  = res(0,30,22'h200000,0,0);
        tag_t[9]  = "gradual";   op_t[9]  = 1'b1; a_t[9]  = opnd(0,1,22'h040000);  b_t[9]  = opnd(0,0,22'h0);      y_t[9]  = res(0,0,22'h080000,0,0);
        tag_t[10] = "mul_sign";  op_t[10] = 1'b0; a_t[10] = opnd(1,32,22'h300000); b_t[10] = opnd(0,31,22'h200000); y_t[10] = res(1,31,22'h300000,0,0);
        tag_t[11] = "add_ovf";   op_t[11] = 1'b1; a_t[11] = opnd(0,63,22'h200000); b_t[11] = opnd(0,63,22'h200000); y_t[11] = res(0,63,22'h3FFFFF,1,0);
        tag_t[12] = "mul_zero";  op_t[12] = 1'b0; a_t[12] = opnd(0,40,22'h0);      b_t[12] = opnd(0,40,22'h200000); y_t[12] = res(0,0,22'h0,0,0);
        tag_t[13] = "shift_rev"; op_t[13] = 1'b1; a_t[13] = opnd(0,15,22'h200000); b_t[13] = opnd(0,40,22'h300000); y_t[13] = res(0,40,22'h300000,0,0);
        tag_t[14] = "sub_bbig";  op_t[14] = 1'b1; a_t[14] = opnd(0,31,22'h100000); b_t[14] = opnd(1,31,22'h300000); y_t[14] = res(1,31,22'h200000,0,0);

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 1'(OP_MUL); a_sgn = 0; b_sgn = 0; a_exp = 0; b_exp = 0; a_man = 0; b_man = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(ypk()), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed single beats
        for (int k = 0; k < NV; k++) run_one(k);
        @(posedge clk); #1;

        // Streaming with consumer stall in cycles 5-7
        idx = 0; got = 0; stall_cyc = 0; stall_bad = 0; held = '0;
        for (int c = 1; c <= 60 && got < 6; c++) begin
            out_ready = !(c >= 5 && c <= 7);
            if (idx < 6) begin
                drive(idx);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc = in_valid & in_ready;
            if (out_valid && out_ready) begin
                chk($sformatf("bp_res%0d", got), 32'(ypk()), 32'(y_t[got]));
                got++;
            end
            if (out_valid && !out_ready) begin
                stall_cyc++;
                if (in_ready) stall_bad++;
                if (stall_cyc > 1 && ypk() !== held) stall_bad++;
                held = ypk();
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        chk("bp_count", 32'(got), 32'd6);
        chk("bp_issued", 32'(idx), 32'd6);
        chk("bp_stall_cycles", 32'(stall_cyc), 32'd3);
        chk("bp_stall_hold", 32'(stall_bad), 32'd0);
        chk("bp_extra", 32'(extra), 32'd0);

        // Reset with one result at the output and three beats in flight
        for (int k = 0; k < 4; k++) begin
            drive(k);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_y", 32'(ypk()), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        chk("mid_stale", 32'(stale), 32'd0);
        run_one(7);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fp_alu_pipe.md
# fp_alu_pipe

Parametrised, fully pipelined floating-point add/multiply unit for the FIR datapath, replacing the fixed-width FPALU. Supports configurable exponent and mantissa widths, a valid/ready handshake with global stall, zero and cancellation handling, full normalisation with exponent adjust, and overflow/underflow flags. It sits between the coefficient/sample fetch logic and the accumulator write-back. Operands use the unified internal format: sign, biased exponent, and a left-aligned mantissa that may be unnormalised.

## Interface
Parameters:
- EXP_W, 6, exponent width
- MAN_W, 22, mantissa width; must equal 2*MUL_W
- MUL_W, 11, multiplier operand width (top MUL_W mantissa bits)
- BIAS, 2**(EXP_W-1)-1, exponent bias

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit accepts a beat this cycle
- in_op  in  1  1 = add, 0 = multiply
- a_sgn, b_sgn  in  1  operand signs
- a_exp, b_exp  in  EXP_W  biased exponents
- a_man, b_man  in  MAN_W  mantissas, value = man/2^MAN_W
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- y_sgn  out  1  result sign
- y_exp  out  EXP_W  result exponent
- y_man  out  MAN_W  result mantissa
- y_ovf, y_unf  out  1  overflow / underflow flags for this result

## Operation
- Value of an operand: (-1)^sgn * (man/2^MAN_W) * 2^(exp-BIAS).
- Multiply:
  - Product = a_man[MAN_W-1 -: MUL_W] * b_man[MAN_W-1 -: MUL_W], MAN_W bits.
  - Exponent = a_exp + b_exp - BIAS, computed at EXP_W+2 bits signed.
  - Sign = a_sgn ^ b_sgn.
- Add:
  - Order the operands by magnitude: larger exponent first, then larger mantissa.
  - Right-shift the smaller mantissa by the exponent difference; bits shifted out are truncated. A shift of MAN_W or more yields 0.
  - Effective subtract when the signs differ.
  - Sum is MAN_W+1 bits. On carry, shift right 1 and add 1 to the exponent.
  - Result sign = sign of the larger operand.
- Normalise:
  - Count leading zeros L of the mantissa.
  - Shift = min(L, exp) when exp ≥ 0 (gradual underflow); exponent -= shift.
- Zero: mantissa 0 (including exact cancellation or any zero operand) gives sgn=0, exp=0, man=0, flags 0.
- Overflow: exponent > 2^EXP_W-1 gives exp all-ones, man all-ones, sign kept, y_ovf=1.
- Underflow: exponent < 0 after multiply gives a flushed zero with y_unf=1.
- A zero operand never contributes its exponent: an add with one zero operand returns the other operand, normalised.

## Timing
- Four register stages, latency 4 cycles from accepted beat to out_valid with no stall:
  - S1: operand compare / multiply
  - S2: align shift
  - S3: add and carry fix
  - S4: LZC, normalise, exponent adjust, flag generation
- Accept on in_valid & in_ready. Result is transferred on out_valid & out_ready.
- in_ready = ~out_valid | out_ready. When low, every stage holds (global stall).
- While out_valid=1 and out_ready=0, all outputs are held stable.
- Bubbles propagate as stage valid=0. Data registers in invalid stages need not update.
- One result per cycle sustained; results leave in issue order.
- Reset, asynchronous and also mid-operation: all stage valids = 0, out_valid=0, y_* = 0, flags 0. In-flight beats are discarded.

## Structure
- Package fp_alu_pkg holds:
  - op encoding constants (OP_ADD=1, OP_MUL=0)
  - the default EXP_W, MAN_W, MUL_W
  - the BIAS function
- Sub-module fp_lzc: parametrised combinational leading-zero counter, width MAN_W, output $clog2(MAN_W+1) bits; all-zero input returns MAN_W.
- The barrel shifters are inline. Pipeline valid/stall control is a single shared enable.

## Test plan
All values use default parameters.
- Add 0.5+0.5: a=(0,31,0x200000), b=(0,31,0x200000) -> after 4 cycles y=(0,32,0x200000), flags 0.
- Multiply 0.5*0.5: same operands, in_op=0 -> y=(0,30,0x200000).
- Cancellation: a=(0,31,0x200000), b=(1,31,0x200000), add -> y=(0,0,0); zero operand (0,40,0) + (1,20,0x300000) -> y=(1,20,0x300000).
- Range: add with exponent difference 25 -> y equals the larger operand. Multiply exp 63*63 with man 0x3FFFFF -> y=(0,63,0x3FFFFF), y_ovf=1. Multiply exp 0*0 -> zero with y_unf=1.
- Back-pressure: stream 6 beats with out_ready low for cycles 5-7 -> in_ready low during the stall, all 6 results in order, none lost or duplicated.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately; no stale result after release.
